// File: rtl/timer_intr_peripheral.sv
// Memory-mapped interval timer with a held level interrupt for the single-cycle CPU data bus.
// Optional programmable prescaler register enabled by defining TIMER_PRESCALE_EN.
module timer_intr_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_8000,
  parameter int unsigned PRESCALE  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] m_addr,
  input  logic [31:0] d_t_mem,
  input  logic        wmem,
  input  logic        rmem,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        intr0
);

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 16;
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_LOAD   = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_PRESC  = 3'd4;

  logic          en_q, auto_q, irq_en_q, pending_q;
  logic [DW-1:0] load_q, count_q;
  logic [PW-1:0] pcnt_q;
  logic          en_d, auto_d, irq_en_d, pending_d;
  logic [DW-1:0] load_d, count_d;
  logic [PW-1:0] pcnt_d;
  logic [PW-1:0] div;
  logic [2:0]    off;
  logic          wr, tick, expire;
  logic          addr_unused;

  assign sel         = (m_addr[31:5] == BASE_ADDR[31:5]);
  assign off         = m_addr[4:2];
  assign wr          = wmem & sel;
  assign addr_unused = ^m_addr[1:0];

`ifdef TIMER_PRESCALE_EN
  logic [PW-1:0] presc_q, presc_d;
  // A programmed divider of 0 behaves as divide-by-1.
  assign div = (presc_q == '0) ? PW'(1) : presc_q;
`else
  localparam logic [PW-1:0] PRESC_FIXED = PW'(PRESCALE);
  assign div = PRESC_FIXED;
`endif

  assign tick   = en_q && (pcnt_q == div - PW'(1));
  assign expire = tick && (count_q == '0);

  // Next-state: timer progress first, then bus writes override.
  always_comb begin
    en_d      = en_q;
    auto_d    = auto_q;
    irq_en_d  = irq_en_q;
    load_d    = load_q;
    count_d   = count_q;
    pcnt_d    = (!en_q || tick) ? '0 : pcnt_q + PW'(1);
`ifdef TIMER_PRESCALE_EN
    presc_d   = presc_q;
`endif
    if (tick) begin
      if (count_q == '0) begin
        if (auto_q) count_d = load_q;
        else        en_d    = 1'b0;
      end else begin
        count_d = count_q - DW'(1);
      end
    end
    if (wr) begin
      case (off)
        OFF_CTRL: begin
          en_d     = d_t_mem[0];
          auto_d   = d_t_mem[1];
          irq_en_d = d_t_mem[2];
          if (d_t_mem[0] && !en_q) pcnt_d = '0;
        end
        OFF_LOAD:  load_d  = d_t_mem;
        OFF_COUNT: count_d = d_t_mem;
`ifdef TIMER_PRESCALE_EN
        OFF_PRESC: begin
          presc_d = d_t_mem[PW-1:0];
          pcnt_d  = '0;
        end
`endif
        default: ;
      endcase
    end
    // An expiry in the same cycle as a W1C keeps pending set.
    pending_d = (pending_q & ~(wr && (off == OFF_STATUS) && d_t_mem[0])) | expire;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      load_q    <= '0;
      count_q   <= '0;
      pcnt_q    <= '0;
      pending_q <= 1'b0;
      intr0     <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      presc_q   <= PW'(PRESCALE);
`endif
    end else begin
      en_q      <= en_d;
      auto_q    <= auto_d;
      irq_en_q  <= irq_en_d;
      load_q    <= load_d;
      count_q   <= count_d;
      pcnt_q    <= pcnt_d;
      pending_q <= pending_d;
      intr0     <= pending_d & irq_en_d;
`ifdef TIMER_PRESCALE_EN
      presc_q   <= presc_d;
`endif
    end
  end

  // Combinational read so the CPU sees data in the same cycle.
  always_comb begin
    rdata = '0;
    if (rmem && sel) begin
      case (off)
        OFF_CTRL:   rdata = {29'd0, irq_en_q, auto_q, en_q};
        OFF_LOAD:   rdata = load_q;
        OFF_COUNT:  rdata = count_q;
        OFF_STATUS: rdata = {31'd0, pending_q};
`ifdef TIMER_PRESCALE_EN
        OFF_PRESC:  rdata = {16'd0, presc_q};
`endif
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_intr_peripheral.sv
// Directed bench for timer_intr_peripheral (instance uses PRESCALE=4).
module tb_timer_intr_peripheral;

  localparam logic [31:0] BASE     = 32'h0000_8000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_LOAD   = BASE + 32'h04;
  localparam logic [31:0] A_COUNT  = BASE + 32'h08;
  localparam logic [31:0] A_STATUS = BASE + 32'h0C;
  localparam logic [31:0] A_PRESC  = BASE + 32'h10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m_addr = '0;
  logic [31:0] d_t_mem = '0;
  logic        wmem = 1'b0;
  logic        rmem = 1'b0;
  logic        sel;
  logic [31:0] rdata;
  logic        intr0;

  int tests = 0;
  int fails = 0;

  timer_intr_peripheral #(.BASE_ADDR(BASE), .PRESCALE(4)) dut (
    .clock(clock), .reset(reset), .m_addr(m_addr), .d_t_mem(d_t_mem),
    .wmem(wmem), .rmem(rmem), .sel(sel), .rdata(rdata), .intr0(intr0)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, 32'(intr0), 32'(exp));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    m_addr  = a;
    d_t_mem = d;
    wmem    = 1'b1;
    @(posedge clock);
    #1;
    wmem = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    m_addr = a;
    rmem   = 1'b1;
    #1;
    v    = rdata;
    rmem = 1'b0;
    check(tag, v, exp);
  endtask

  initial begin
    // Reset state
    #2;
    chk_irq("rst_intr0", 1'b0);
    rdchk("rst_ctrl", A_CTRL, 32'h0);
    rdchk("rst_load", A_LOAD, 32'h0);
    @(negedge clock); #1;
    rdchk("rst_count", A_COUNT, 32'h0);
    rdchk("rst_status", A_STATUS, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // One-shot: COUNT=3, P=4 -> expiry on the 16th edge after the CTRL write
    wr(A_COUNT, 32'd3);
    wr(A_LOAD, 32'h99);
    wr(A_CTRL, 32'h5);
    cyc(15);
    rdchk("os_pend_pre", A_STATUS, 32'h0);
    chk_irq("os_intr_pre", 1'b0);
    cyc(1);
    rdchk("os_pend", A_STATUS, 32'h1);
    chk_irq("os_intr", 1'b1);
    rdchk("os_ctrl", A_CTRL, 32'h4);
    cyc(5);
    rdchk("os_count_hold", A_COUNT, 32'h0);
    rdchk("os_ctrl_hold", A_CTRL, 32'h4);
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
    rdchk("os_clear", A_STATUS, 32'h0);

    // Auto-reload: LOAD=1 -> expiry every 8 cycles
    wr(A_LOAD, 32'd1);
    wr(A_COUNT, 32'd1);
    wr(A_CTRL, 32'h7);
    cyc(7);
    chk_irq("ar_intr_pre", 1'b0);
    cyc(1);
    chk_irq("ar_intr1", 1'b1);
    rdchk("ar_reload", A_COUNT, 32'h1);
    wr(A_STATUS, 32'h1);
    chk_irq("ar_w1c_drop", 1'b0);
    rdchk("ar_w1c_status", A_STATUS, 32'h0);
    cyc(6);
    chk_irq("ar_intr2_pre", 1'b0);
    cyc(1);
    chk_irq("ar_intr2", 1'b1);

    // Races: W1C on the expiry edge, COUNT write on a tick edge
    cyc(7);
    wr(A_STATUS, 32'h1);
    rdchk("race_w1c_pend", A_STATUS, 32'h1);
    chk_irq("race_w1c_intr", 1'b1);
    rdchk("race_w1c_reload", A_COUNT, 32'h1);
    cyc(3);
    wr(A_COUNT, 32'h20);
    rdchk("race_cnt_wr", A_COUNT, 32'h20);
    cyc(4);
    rdchk("race_cnt_next", A_COUNT, 32'h1F);
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
    chk_irq("race_clear", 1'b0);

    // Simultaneous read and write returns the old value
    @(negedge clock);
    m_addr = A_LOAD; d_t_mem = 32'h55; wmem = 1'b1; rmem = 1'b1;
    #1;
    check("rw_old", rdata, 32'h1);
    @(posedge clock); #1;
    wmem = 1'b0; rmem = 1'b0;
    rdchk("rw_new", A_LOAD, 32'h55);

    // Mask: irq_en=0 still records the expiry
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h1);
    cyc(3);
    rdchk("mask_pend_pre", A_STATUS, 32'h0);
    cyc(1);
    rdchk("mask_pend", A_STATUS, 32'h1);
    chk_irq("mask_intr", 1'b0);
    rdchk("mask_ctrl", A_CTRL, 32'h0);
    wr(A_CTRL, 32'h4);
    chk_irq("unmask_intr", 1'b1);

    // Decode
    @(negedge clock);
    m_addr = BASE + 32'h20; rmem = 1'b1;
    #1;
    check("dec_sel_out", 32'(sel), 32'h0);
    check("dec_rdata_out", rdata, 32'h0);
    m_addr = BASE + 32'h1F;
    #1;
    check("dec_sel_in", 32'(sel), 32'h1);
    rmem = 1'b0;
    wr(BASE + 32'h18, 32'hFFFF_FFFF);
    wr(BASE + 32'h20, 32'h0);
    rdchk("dec_ctrl", A_CTRL, 32'h4);
    rdchk("dec_load", A_LOAD, 32'h55);
    rdchk("dec_count", A_COUNT, 32'h0);
    @(negedge clock); #1;
    rdchk("dec_status", A_STATUS, 32'h1);
    chk_irq("dec_intr", 1'b1);
    m_addr = A_CTRL;
    #1;
    check("rdata_no_rmem", rdata, 32'h0);
    wr(A_STATUS, 32'h1);

`ifdef TIMER_PRESCALE_EN
    // Programmable prescaler: 0 acts as divide-by-1
    rdchk("presc_reset", A_PRESC, 32'd4);
    wr(A_PRESC, 32'h0);
    wr(A_COUNT, 32'd2);
    wr(A_CTRL, 32'h5);
    cyc(2);
    rdchk("presc_pend_pre", A_STATUS, 32'h0);
    cyc(1);
    rdchk("presc_pend", A_STATUS, 32'h1);
    chk_irq("presc_intr", 1'b1);
    wr(A_STATUS, 32'h1);
`else
    rdchk("presc_absent", A_PRESC, 32'h0);
    wr(A_PRESC, 32'h1234);
    rdchk("presc_wr_ignored", A_PRESC, 32'h0);
`endif

    // Reset asserted mid-run
    wr(A_LOAD, 32'd7);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h7);
    cyc(4);
    chk_irq("mid_intr_pre", 1'b1);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk_irq("mid_rst_intr", 1'b0);
    rdchk("mid_rst_ctrl", A_CTRL, 32'h0);
    @(negedge clock); #1;
    rdchk("mid_rst_load", A_LOAD, 32'h0);
    rdchk("mid_rst_count", A_COUNT, 32'h0);
    m_addr = A_CTRL; rmem = 1'b0;
    #1;
    check("mid_rst_rdata", rdata, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    cyc(2);
    rdchk("post_rst_status", A_STATUS, 32'h0);
    chk_irq("post_rst_intr", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
